// File: rtl/sys_defs_pkg.sv
// Shared system definitions: memory command encoding, arbiter FSM states and
// the default fetch-starvation limit used by the unified memory arbiter.
package sys_defs;

  // Command encoding shared by the data port and the unified memory port.
  typedef enum logic [1:0] {
    CmdNone  = 2'd0,
    CmdLoad  = 2'd1,
    CmdStore = 2'd2
  } mem_cmd_t;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbWaitI = 2'd1,
    ArbWaitD = 2'd2
  } arb_state_t;

  localparam int unsigned StarveLimitDefault = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Unified memory arbiter: shares one single-outstanding memory port between the
// instruction fetch port and the data port. Data normally wins; a pending
// fetch is forced through after STARVE_LIMIT consecutive data grants.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/if_flush  fetch request, address, discard in-flight fetch
//   if_instr/if_data_valid   registered instruction and its one-cycle pulse
//   if_stall                 fetch not yet satisfied
//   dmem_cmd/addr/wdata      data command (NONE/LOAD/STORE), address, store data
//   dmem_rdata/dmem_done     registered load data and completion pulse
//   dmem_stall               data command not yet complete
//   mem_cmd/addr/wdata       command to memory (combinational in IDLE)
//   mem_ready                memory accepts mem_cmd this cycle
//   mem_rvalid/mem_rdata     read response
module mem_arbiter
  import sys_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_instr,
  output logic        if_data_valid,
  output logic        if_stall,
  input  logic [1:0]  dmem_cmd,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_done,
  output logic        dmem_stall,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  arb_state_t      state_q;
  logic [CntW-1:0] starve_cnt_q;
  logic            drop_q;

  logic data_valid;
  logic fetch_valid;
  logic grant_fetch;
  logic grant_data;
  logic accept;
  logic starved;

  assign if_stall   = if_req & ~if_data_valid;
  assign dmem_stall = (dmem_cmd != CmdNone) & ~dmem_done;
  assign starved    = (starve_cnt_q == CntW'(STARVE_LIMIT));

  always_comb begin
    // A requester whose completion pulse is high this cycle is still holding
    // the old request; masking it prevents a duplicate issue.
    data_valid  = ((dmem_cmd == CmdLoad) || (dmem_cmd == CmdStore)) && !dmem_done;
    fetch_valid = if_req && !if_data_valid;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (state_q == ArbIdle) begin
      grant_fetch = fetch_valid && (!data_valid || starved);
      grant_data  = data_valid && !grant_fetch;
    end

    mem_cmd   = CmdNone;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (grant_fetch) begin
      mem_cmd  = CmdLoad;
      mem_addr = {if_addr[31:2], 2'b00};
    end else if (grant_data) begin
      mem_cmd  = dmem_cmd;
      mem_addr = {dmem_addr[31:2], 2'b00};
      if (dmem_cmd == CmdStore) begin
        mem_wdata = dmem_wdata;
      end
    end

    accept = (mem_cmd != CmdNone) && mem_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ArbIdle;
      starve_cnt_q  <= '0;
      drop_q        <= 1'b0;
      if_instr      <= 32'h0;
      if_data_valid <= 1'b0;
      dmem_rdata    <= 32'h0;
      dmem_done     <= 1'b0;
    end else begin
      if_data_valid <= 1'b0;
      dmem_done     <= 1'b0;

      if (!if_req || (accept && grant_fetch)) begin
        starve_cnt_q <= '0;
      end else if (accept && grant_data && !starved) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end

      case (state_q)
        ArbIdle: begin
          if (accept) begin
            if (grant_fetch) begin
              state_q <= ArbWaitI;
              drop_q  <= if_flush;
            end else if (dmem_cmd == CmdStore) begin
              // Stores are posted: complete as soon as memory takes them.
              dmem_done <= 1'b1;
            end else begin
              state_q <= ArbWaitD;
            end
          end
        end
        ArbWaitI: begin
          if (mem_rvalid) begin
            state_q <= ArbIdle;
            drop_q  <= 1'b0;
            if (!drop_q && !if_flush) begin
              if_instr      <= mem_rdata;
              if_data_valid <= 1'b1;
            end
          end else if (if_flush) begin
            drop_q <= 1'b1;
          end
        end
        ArbWaitD: begin
          if (mem_rvalid) begin
            state_q    <= ArbIdle;
            dmem_rdata <= mem_rdata;
            dmem_done  <= 1'b1;
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

endmodule
